// File: rtl/chan_mux_pkg.sv
// Shared definitions for the channel multiplexer: arbitration mode encodings
// and the channel-index width helper.
package chan_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Index width for n channels; never narrower than one bit.
  function automatic int ch_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chan_mux_rr_pick.sv
// Round-robin search: finds the first requesting channel after 'last',
// wrapping around, and reports whether any channel requested at all.
module rr_pick #(
  parameter int NCH = 8,
  parameter int SW  = 3
) (
  input  logic [NCH-1:0] req,
  input  logic [SW-1:0]  last,
  output logic [SW-1:0]  grant,
  output logic           grant_valid
);

  logic [2*NCH-1:0] req_dbl;
  logic [NCH-1:0]   req_rot;
  int               shamt;

  // Rotate so that bit 0 of req_rot is channel (last+1) mod NCH.
  always_comb begin
    shamt   = int'(last) + 1;
    req_dbl = {req, req} >> shamt;
    req_rot = req_dbl[NCH-1:0];
  end

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    for (int j = 0; j < NCH; j++) begin
      if (!grant_valid && req_rot[j]) begin
        grant_valid = 1'b1;
        grant       = SW'((int'(last) + 1 + j) % NCH);
      end
    end
  end

endmodule

// File: rtl/chan_mux_rr.sv
// N-channel to one multiplexer with fixed-select or round-robin arbitration and
// a single output register. Define CHAN_MUX_RR_LOCK_EN to add in_last packet locking.
//
// Handshake (both sides): a beat moves on a rising edge where valid and ready
// are both 1. valid never waits on ready; in_ready is combinational from
// in_valid, mode, sel and the output register state; out_data/out_ch hold
// while out_valid=1 and out_ready=0.
module chan_mux_rr
  import chan_mux_pkg::*;
#(
  parameter int NCH = 8,
  parameter int W   = 8,
  parameter int SW  = ch_idx_w(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [SW-1:0]    sel,
  input  logic [NCH-1:0]   in_valid,
  input  logic [NCH*W-1:0] in_data,
`ifdef CHAN_MUX_RR_LOCK_EN
  input  logic [NCH-1:0]   in_last,
`endif
  output logic [NCH-1:0]   in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [SW-1:0]    out_ch
);

  logic [SW-1:0] last_q;
  logic          load_en;
  logic [SW-1:0] rr_grant;
  logic          rr_valid;
  logic          fix_valid;
  logic [SW-1:0] grant_idx;
  logic          grant_valid;
  logic          xfer;
  logic [W-1:0]  grant_data;

  rr_pick #(
    .NCH (NCH),
    .SW  (SW)
  ) u_rr_pick (
    .req         (in_valid),
    .last        (last_q),
    .grant       (rr_grant),
    .grant_valid (rr_valid)
  );

  // A sel value with no matching channel leaves fix_valid low: nothing granted.
  always_comb begin
    fix_valid = 1'b0;
    for (int g = 0; g < NCH; g++) begin
      if (sel == SW'(g)) fix_valid = in_valid[g];
    end
  end

`ifdef CHAN_MUX_RR_LOCK_EN
  logic          lock_q;
  logic [SW-1:0] lock_ch_q;
  logic          lock_valid;
  logic          grant_last;

  always_comb begin
    lock_valid = 1'b0;
    grant_last = 1'b0;
    for (int g = 0; g < NCH; g++) begin
      if (lock_ch_q == SW'(g)) lock_valid = in_valid[g];
      if (grant_idx == SW'(g)) grant_last = in_last[g];
    end
  end

  // While locked, mode and sel are ignored until the in_last beat moves.
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    if (lock_q) begin
      grant_idx   = lock_ch_q;
      grant_valid = lock_valid;
    end else if (mode == MODE_RR) begin
      grant_idx   = rr_grant;
      grant_valid = rr_valid;
    end else begin
      grant_idx   = sel;
      grant_valid = fix_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else if (xfer) begin
      lock_q    <= !grant_last;
      lock_ch_q <= grant_idx;
    end
  end
`else
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    if (mode == MODE_RR) begin
      grant_idx   = rr_grant;
      grant_valid = rr_valid;
    end else begin
      grant_idx   = sel;
      grant_valid = fix_valid;
    end
  end
`endif

  assign load_en = !out_valid || out_ready;
  assign xfer    = rst_n && load_en && grant_valid;

  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int g = 0; g < NCH; g++) begin
      if (grant_idx == SW'(g)) begin
        in_ready[g] = xfer;
        grant_data  = in_data[g*W +: W];
      end
    end
  end

  // Output register; a drain and a new load in the same cycle replace the beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      last_q    <= SW'(NCH - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_ch    <= grant_idx;
      last_q    <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_chan_mux_rr.sv
// Directed bench for chan_mux_rr: drivers push expected {ch,data} beats into a
// queue, and a monitor pops and compares on every accepted output beat.
module tb_chan_mux_rr;

  localparam int NCH = 8;
  localparam int W   = 8;
  localparam int SW  = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             mode;
  logic [SW-1:0]    sel;
  logic [NCH-1:0]   in_valid;
  logic [NCH*W-1:0] in_data;
  logic [NCH-1:0]   in_last;
  logic [NCH-1:0]   in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [SW-1:0]    out_ch;

  logic [SW+W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  chan_mux_rr #(.NCH(NCH), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef CHAN_MUX_RR_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [W-1:0] val);
    in_data[ch*W +: W] = val;
  endtask

  task automatic expect_beat(input int ch, input logic [W-1:0] val);
    logic [SW-1:0] c;
    c = SW'(ch);
    exp_q.push_back({c, val});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      logic [SW+W-1:0] exp_beat;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got ch=%0d data=%0h, required no beat", out_ch, out_data);
      end else begin
        exp_beat = exp_q.pop_front();
        if ({out_ch, out_data} !== exp_beat) begin
          errors++;
          $display("FAIL beat: got ch=%0d data=%0h, required ch=%0d data=%0h",
                   out_ch, out_data, exp_beat[SW+W-1:W], exp_beat[W-1:0]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; mode = 1'b0; sel = '0; in_valid = '0; in_data = '0;
    in_last = '0; out_ready = 1'b1;

    // reset state, with requests present
    step(2);
    mode = 1'b1; in_valid = 8'hFF;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_ch", 32'(out_ch), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    in_valid = '0;
    @(negedge clk); rst_n = 1'b1;
    step(1);

    // fixed select, channel 3, 1-cycle latency
    mode = 1'b0; sel = 3'd3; in_valid = 8'h08; set_data(3, 8'hA5);
    #1;
    check("fix3_in_ready", 32'(in_ready), 32'h08);
    expect_beat(3, 8'hA5);
    step(1);
    check("fix3_out_valid", 32'(out_valid), 32'd1);
    check("fix3_out_data", 32'(out_data), 32'hA5);
    check("fix3_out_ch", 32'(out_ch), 32'd3);
    in_valid = '0;
    step(1);

    // fixed select ignores other valid channels; unselected-invalid grants nothing
    sel = 3'd6; in_valid = 8'h41; set_data(6, 8'h66);
    #1;
    check("fix6_in_ready", 32'(in_ready), 32'h40);
    expect_beat(6, 8'h66);
    step(1);
    sel = 3'd2;
    #1;
    check("fix2_idle_in_ready", 32'(in_ready), 32'h00);
    in_valid = '0;
    step(2);

    // round-robin with no requests
    mode = 1'b1;
    #1;
    check("rr_none_in_ready", 32'(in_ready), 32'h00);

    // round-robin full sweep from reset: 0..7 then 0
    do_reset();
    for (int k = 0; k < NCH; k++) set_data(k, 8'(8'h10 + k));
    in_valid = 8'hFF;
    for (int k = 0; k < NCH; k++) expect_beat(k, 8'(8'h10 + k));
    expect_beat(0, 8'h10);
    step(9);
    in_valid = '0;
    step(2);

    // wrap-around: last=0, requests on 7 and 0
    in_valid = 8'h81; set_data(7, 8'h77); set_data(0, 8'h0F);
    #1;
    check("wrap_first_in_ready", 32'(in_ready), 32'h80);
    expect_beat(7, 8'h77);
    expect_beat(0, 8'h0F);
    step(1);
    check("wrap_second_in_ready", 32'(in_ready), 32'h01);
    step(1);
    in_valid = '0;
    step(2);

    // backpressure: hold for 5 cycles, then drain and reload in one cycle
    out_ready = 1'b0; in_valid = 8'h04; set_data(2, 8'hC2);
    expect_beat(2, 8'hC2);
    step(1);
    in_valid = 8'h08; set_data(3, 8'hD3);
    expect_beat(3, 8'hD3);
    for (int c = 0; c < 5; c++) begin
      check("stall_in_ready", 32'(in_ready), 32'h00);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_data", 32'(out_data), 32'hC2);
      check("stall_out_ch", 32'(out_ch), 32'd2);
      step(1);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(in_ready), 32'h08);
    step(1);
    check("reload_out_data", 32'(out_data), 32'hD3);
    check("reload_out_ch", 32'(out_ch), 32'd3);
    in_valid = '0;
    step(1);
    check("drain_out_valid", 32'(out_valid), 32'd0);

    // reset mid-stream: beat 5 is discarded, first grant after release is 0
    for (int k = 0; k < NCH; k++) set_data(k, 8'(8'h40 + k));
    in_valid = 8'hFF;
    expect_beat(4, 8'h44);
    step(2);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'h00);
    expect_beat(0, 8'h40);
    @(negedge clk); rst_n = 1'b1;
    step(1);
    in_valid = '0;
    step(2);

`ifdef CHAN_MUX_RR_LOCK_EN
    // 3-beat packet on channel 2 holds off channel 5; mode/sel changes ignored
    in_valid = 8'h24; set_data(2, 8'hB0); set_data(5, 8'hE5); in_last = '0;
    #1;
    check("lock_b0_in_ready", 32'(in_ready), 32'h04);
    expect_beat(2, 8'hB0);
    step(1);
    mode = 1'b0; sel = 3'd5; set_data(2, 8'hB1);
    #1;
    check("lock_b1_in_ready", 32'(in_ready), 32'h04);
    expect_beat(2, 8'hB1);
    step(1);
    set_data(2, 8'hB2); in_last = 8'h04;
    #1;
    check("lock_b2_in_ready", 32'(in_ready), 32'h04);
    expect_beat(2, 8'hB2);
    step(1);
    in_last = '0;
    #1;
    check("lock_ch5_in_ready", 32'(in_ready), 32'h20);
    expect_beat(5, 8'hE5);
    step(1);
    in_valid = '0; mode = 1'b1;
    step(2);
`endif

    // final report
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) step(1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chan_mux_rr.md
CHAN_MUX_RR -- requirements
Module: chan_mux_rr

Interface
REQ-001 SHALL have parameter NCH, default 8, meaning the number of input channels (legal values 2..32).
REQ-002 SHALL have parameter W, default 8, meaning the data width per channel.
REQ-003 SHALL have parameter SW, default $clog2(NCH), meaning the select/channel-index width.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port mode  input  1  arbitration mode: 0 = fixed select, 1 = round-robin.
REQ-007 SHALL have port sel  input  SW  channel index used in fixed mode.
REQ-008 SHALL have port in_valid  input  NCH  per-channel valid.
REQ-009 SHALL have port in_data  input  NCH*W  packed channel data; channel k occupies bits [k*W +: W].
REQ-010 SHALL have port in_ready  output  NCH  per-channel ready, at most one bit set.
REQ-011 SHALL have port out_valid  output  1  output register holds a beat.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the beat.
REQ-013 SHALL have port out_data  output  W  registered selected data.
REQ-014 SHALL have port out_ch  output  SW  index of the channel that supplied out_data.

Function
REQ-015 SHALL have a single output register stage; load_en = !out_valid | out_ready.
REQ-016 SHALL assert in_ready[g] combinationally only when load_en=1 and g is the granted channel with in_valid[g]=1.
REQ-017 SHALL, on a cycle with in_valid[g] & in_ready[g], load out_data=in_data[g], out_ch=g and set out_valid=1 on the next edge, giving 1-cycle latency.
REQ-018 SHALL clear out_valid on a cycle with out_valid & out_ready and no new transfer; if both occur, SHALL replace the beat without a bubble.
REQ-019 SHALL hold out_data/out_ch/out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL, in fixed mode, grant channel sel; if sel >= NCH, SHALL grant nothing and all in_ready SHALL be 0.
REQ-021 SHALL, in round-robin mode, grant the first channel with in_valid set, searching from (last+1) mod NCH upward with wrap-around; last SHALL update only on a completed input transfer.
REQ-022 SHALL grant nothing and leave last unchanged when no in_valid bit is set.
REQ-023 SHALL apply a mode or sel change on the first cycle it is presented; an already-loaded output beat is unaffected.

Reset
REQ-024 SHALL, while rst_n=0, force out_valid=0, out_data=0, out_ch=0, and last=NCH-1, so that channel 0 has first priority after reset.
REQ-025 SHALL, on reset asserted mid-transfer, discard the held beat immediately; in_ready SHALL be 0 during reset.

Configuration
REQ-026 SHALL support the macro CHAN_MUX_RR_LOCK_EN. When it is defined, the block SHALL add port in_last  input  NCH, SHALL hold the grant on the current channel from its first transferred beat until a beat with in_last set is transferred, and SHALL ignore mode and sel changes during that time. When it is undefined, the block SHALL have no in_last port and SHALL re-arbitrate on every beat.
REQ-027 SHALL, with lock enabled, clear the lock on reset.

Structure
REQ-028 SHALL place the mode encodings (MODE_FIXED=0, MODE_RR=1) and the channel-index width helper in the shared package chan_mux_pkg.
REQ-029 SHALL implement the round-robin search as the sub-module rr_pick (inputs: request vector, last; outputs: grant index, grant valid).

Verification
REQ-030 SHALL cover: mode=0, sel=3, in_valid=8'h08, data3=8'hA5, out_ready=1 -> in_ready=8'h08, and out_data=A5 with out_ch=3 one cycle later.
REQ-031 SHALL cover: mode=1, in_valid=8'hFF held, out_ready=1 after reset -> out_ch sequence 0,1,...,7,0.
REQ-032 SHALL cover: mode=1, in_valid=8'h81, last=0 -> grant 7, then 0 (wrap-around).
REQ-033 SHALL cover: out_ready=0 for 5 cycles with a beat held -> output stable and in_ready=0; on release the next beat is loaded in the same cycle as the drain.
REQ-034 SHALL cover: rst_n pulsed low mid-stream -> out_valid=0 asynchronously, and the first grant after release goes to channel 0.
REQ-035 SHALL cover, with CHAN_MUX_RR_LOCK_EN: a 3-beat packet on channel 2 while channel 5 is valid -> channel 5 is granted only after the beat with in_last[2]=1.
